amcxtfif_fab_wr: RTL and testbench
==================================

AMCXTFIF_FAB_WR -- requirements
Module: amcxtfif_fab_wr

Interface
REQ-001 Parameter RABITS, 12, FIFO RAM address width; depth 2^RABITS words.
REQ-002 Parameter DWIDTH, 32, fabric data width; RAM word width DWIDTH+4.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  fabric word valid.
REQ-006 in_ready  out  1  block accepts word; transfer when in_valid & in_ready.
REQ-007 in_data  in  DWIDTH  frame data word.
REQ-008 in_sof / in_eof  in  1 each  first / last word of frame.
REQ-009 in_bcnt  in  2  valid bytes in eof word; 0 means all four.
REQ-010 in_abort  in  1  discard frame in progress.
REQ-011 rd_ptr_sync  in  RABITS+1  MAC-side read pointer, already synchronized to clk, binary.
REQ-012 ram_we  out  1  RAM write strobe.
REQ-013 ram_waddr  out  RABITS  RAM write address.
REQ-014 ram_wdata  out  DWIDTH+4  {eof, sof, bcnt[1:0], data}.
REQ-015 wr_ptr_commit  out  RABITS+1  pointer past last complete frame; MAC reads only below it.
REQ-016 frame_done  out  1  one-cycle pulse per committed frame.
REQ-017 drop_err  out  1  one-cycle pulse per discarded frame or stray word.
REQ-018 free_words  out  RABITS+1  2^RABITS - (wr_ptr - rd_ptr_sync), mod 2^(RABITS+1).

Function
REQ-019 Internal working pointer wr_ptr (RABITS+1 bits, wraps mod 2^(RABITS+1)); full when wr_ptr - rd_ptr_sync == 2^RABITS.
REQ-020 States IDLE, FRAME, DROP; in_ready = ~full in IDLE/FRAME, 1 in DROP.
REQ-021 Accepted written word: next cycle ram_we=1, ram_waddr=wr_ptr[RABITS-1:0], ram_wdata as REQ-014; wr_ptr increments same edge as acceptance; write latency 1 cycle.
REQ-022 IDLE, accepted sof&~eof: write, go FRAME; sof&eof: write, commit, stay IDLE.
REQ-023 IDLE, accepted ~sof: word not written, drop_err pulse, stay IDLE.
REQ-024 FRAME, accepted ~sof&~eof: write; ~sof&eof: write, commit, go IDLE.
REQ-025 FRAME, accepted sof: wr_ptr rewinds to wr_ptr_commit, drop_err pulse, word written at wr_ptr_commit as new frame start, stay FRAME (go IDLE with commit if eof also set).
REQ-026 Commit: wr_ptr_commit <= post-increment wr_ptr one cycle after eof acceptance, coincident with eof's ram_we; frame_done pulses same cycle.
REQ-027 in_abort in FRAME: wr_ptr rewinds to wr_ptr_commit, drop_err pulse, go IDLE; concurrent accepted word discarded (abort wins). in_abort in IDLE/DROP ignored.
REQ-028 Oversize: in FRAME with full and wr_ptr_commit == rd_ptr_sync, rewind, drop_err pulse, go DROP.
REQ-029 DROP: accept and discard all words; on accepted eof go IDLE; sof in DROP ignored.
REQ-030 wr_ptr_commit never decreases; rewind never moves wr_ptr below wr_ptr_commit.
REQ-031 free_words registered, updated one cycle after wr_ptr or rd_ptr_sync change.

Reset
REQ-032 rst_n low at clk edge: state IDLE, wr_ptr=0, wr_ptr_commit=0, ram_we=0, ram_waddr=0, ram_wdata=0, frame_done=0, drop_err=0, free_words=2^RABITS, counters 0.
REQ-033 Reset mid-frame discards the partial frame; no frame_done.
REQ-034 in_ready=0 while rst_n low.

Configuration
REQ-035 Macro CORETSE_TXFIF_STATS_EN defined: outputs frame_cnt[15:0] (increments on frame_done) and drop_cnt[15:0] (increments on drop_err), both saturating at 16'hFFFF.
REQ-036 Macro undefined: frame_cnt and drop_cnt ports present, tied 0, no counter flops.

Verification
REQ-037 RABITS=4, 3-word frame sof..eof bcnt=2, rd_ptr_sync=0 -> ram_waddr 0,1,2; wdata[35:32]=4'b0100,0000,1010; wr_ptr_commit=3, frame_done once.
REQ-038 Empty FIFO, rd_ptr_sync=0, 16 writes without eof -> full, in_ready stays 0... then DROP: drop_err, wr_ptr_commit=0, words until eof discarded, return IDLE.
REQ-039 Frame of 2 words then in_abort with in_valid=1 -> drop_err, no write that cycle, next sof written at address wr_ptr_commit.
REQ-040 wr_ptr=0x1E, rd_ptr_sync=0x1E, 4-word frame -> addresses E,F,0,1; wr_ptr_commit=0x02; free_words=12.
REQ-041 Word without sof in IDLE -> drop_err, ram_we stays 0.
REQ-042 rst_n low mid-frame -> all REQ-032 values next cycle; with/without CORETSE_TXFIF_STATS_EN check frame_cnt counts vs tied 0.

Source files
------------

// File: rtl/amcxtfif_fab_wr.sv
// Fabric-side write engine of the TX frame FIFO: stores frame words in RAM and commits whole frames.
// Define CORETSE_TXFIF_STATS_EN to build the saturating frame/drop statistics counters.
module amcxtfif_fab_wr #(
  parameter int unsigned RABITS = 12,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [1:0]        in_bcnt,
  input  logic              in_abort,
  input  logic [RABITS:0]   rd_ptr_sync,
  output logic              ram_we,
  output logic [RABITS-1:0] ram_waddr,
  output logic [DWIDTH+3:0] ram_wdata,
  output logic [RABITS:0]   wr_ptr_commit,
  output logic              frame_done,
  output logic              drop_err,
  output logic [RABITS:0]   free_words,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} state_e;

  localparam logic [RABITS:0] One   = (RABITS + 1)'(1);
  localparam logic [RABITS:0] Depth = One << RABITS;

  state_e              state_q, state_d;
  logic [RABITS:0]     wr_ptr_q, wr_ptr_d;
  logic [RABITS:0]     commit_q, commit_d;
  logic                we_q, we_d;
  logic [RABITS-1:0]   waddr_q, waddr_d;
  logic [DWIDTH+3:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic [RABITS:0]     free_q;

  logic [RABITS:0]     used;
  logic                full;
  logic                accept;
  logic                do_write;
  logic [RABITS:0]     wr_at;

  assign used     = wr_ptr_q - rd_ptr_sync;
  assign full     = (used == Depth);
  assign in_ready = rst_n & ((state_q == StDrop) | ~full);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    do_write = 1'b0;
    wr_at    = wr_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_sof) do_write = 1'b1;
          else        drop_d   = 1'b1;
        end
      end
      StFrame: begin
        if (in_abort) begin
          wr_ptr_d = commit_q;
          drop_d   = 1'b1;
          state_d  = StIdle;
        end else if (full && (commit_q == rd_ptr_sync)) begin
          // Frame alone fills the whole RAM: it can never be committed.
          wr_ptr_d = commit_q;
          drop_d   = 1'b1;
          state_d  = StDrop;
        end else if (accept) begin
          do_write = 1'b1;
          if (in_sof) begin
            drop_d = 1'b1;
            wr_at  = commit_q;
          end
        end
      end
      StDrop: begin
        if (accept && in_eof) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (do_write) begin
      we_d     = 1'b1;
      waddr_d  = wr_at[RABITS-1:0];
      wdata_d  = {in_eof, in_sof, in_bcnt, in_data};
      wr_ptr_d = wr_at + One;
      if (in_eof) begin
        commit_d = wr_at + One;
        done_d   = 1'b1;
        state_d  = StIdle;
      end else begin
        state_d  = StFrame;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      commit_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      free_q   <= Depth;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      free_q   <= Depth - used;
    end
  end

  assign ram_we        = we_q;
  assign ram_waddr     = waddr_q;
  assign ram_wdata     = wdata_q;
  assign wr_ptr_commit = commit_q;
  assign frame_done    = done_q;
  assign drop_err      = drop_q;
  assign free_words    = free_q;

`ifdef CORETSE_TXFIF_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  // Counters advance in step with the visible pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (done_d && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop_d && (drop_cnt_q != 16'hFFFF))  drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign frame_cnt = 16'd0;
  assign drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_amcxtfif_fab_wr.sv
// Self-checking bench for amcxtfif_fab_wr (RABITS=4): directed scenarios plus random frames
// checked against a frame-level model (committed base + length of the open frame).
module tb_amcxtfif_fab_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic [1:0]  in_bcnt = '0;
  logic        in_abort = 1'b0;
  logic [4:0]  rd_ptr_sync = '0;
  logic        ram_we;
  logic [3:0]  ram_waddr;
  logic [35:0] ram_wdata;
  logic [4:0]  wr_ptr_commit;
  logic        frame_done;
  logic        drop_err;
  logic [4:0]  free_words;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  amcxtfif_fab_wr #(.RABITS(4), .DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .in_bcnt(in_bcnt), .in_abort(in_abort),
    .rd_ptr_sync(rd_ptr_sync), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .wr_ptr_commit(wr_ptr_commit), .frame_done(frame_done), .drop_err(drop_err),
    .free_words(free_words), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Frame-level reference model.
  logic [4:0]  m_base;
  int          m_len;
  int          m_mode;  // 0 idle, 1 in frame, 2 dropping
  int          m_frames;
  int          m_drops;
  logic        m_ready;
  logic        obs_ready;
  logic        exp_we, exp_fd, exp_de;
  logic [3:0]  exp_waddr;
  logic [35:0] exp_wdata;
  logic [4:0]  exp_free;

  task automatic model_step();
    logic [4:0] wr, used, at;
    logic       acc, wr_now;
    wr      = m_base + 5'(m_len);
    used    = wr - rd_ptr_sync;
    m_ready = rst_n && (m_mode == 2 || used != 5'd16);
    acc     = in_valid && m_ready;
    exp_we  = 1'b0;
    exp_fd  = 1'b0;
    exp_de  = 1'b0;
    wr_now  = 1'b0;
    at      = wr;
    if (!rst_n) begin
      m_base = '0; m_len = 0; m_mode = 0; m_frames = 0; m_drops = 0;
      exp_waddr = '0; exp_wdata = '0; exp_free = 5'd16;
      return;
    end
    exp_free = 5'd16 - used;
    case (m_mode)
      0: if (acc) begin
        if (in_sof) wr_now = 1'b1;
        else        exp_de = 1'b1;
      end
      1: begin
        if (in_abort) begin
          m_len = 0; exp_de = 1'b1; m_mode = 0;
        end else if (used == 5'd16 && m_base == rd_ptr_sync) begin
          m_len = 0; exp_de = 1'b1; m_mode = 2;
        end else if (acc) begin
          wr_now = 1'b1;
          if (in_sof) begin
            exp_de = 1'b1; m_len = 0; at = m_base;
          end
        end
      end
      default: if (acc && in_eof) m_mode = 0;
    endcase
    if (wr_now) begin
      exp_we    = 1'b1;
      exp_waddr = at[3:0];
      exp_wdata = {in_eof, in_sof, in_bcnt, in_data};
      m_len++;
      if (in_eof) begin
        m_base = m_base + 5'(m_len); m_len = 0; exp_fd = 1'b1; m_mode = 0;
      end else begin
        m_mode = 1;
      end
    end
    if (exp_fd) m_frames++;
    if (exp_de) m_drops++;
  endtask

  task automatic cycle(input logic v, input logic s, input logic e, input logic [1:0] b,
                       input logic [31:0] d, input logic ab);
    @(negedge clk);
    in_valid = v; in_sof = s; in_eof = e; in_bcnt = b; in_data = d; in_abort = ab;
    #1;
    obs_ready = in_ready;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_ptr_sync = '0;
    idle();
    idle();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef CORETSE_TXFIF_STATS_EN
    return 16'(n);
`else
    return 16'd0 + 16'(n * 0);
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", obs_ready); end
    idle();
    rst_n = 1'b1;
    total++;
    if ({ram_we, ram_waddr, ram_wdata, wr_ptr_commit, frame_done, drop_err} !== '0) begin
      bad++;
      $display("FAIL reset_regs we=%b wa=%h wd=%h cm=%h fd=%b de=%b exp all 0",
               ram_we, ram_waddr, ram_wdata, wr_ptr_commit, frame_done, drop_err);
    end
    total++; if (free_words !== 5'd16) begin bad++; $display("FAIL reset_free got=%0d exp=16", free_words); end
    total++;
    if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt fc=%0d dc=%0d exp 0", frame_cnt, drop_cnt);
    end
  endtask

  task automatic test_basic_frame();
    logic [3:0] nib [3];
    logic [31:0] dat [3];
    nib[0] = 4'b0100; nib[1] = 4'b0000; nib[2] = 4'b1010;
    dat[0] = 32'hA0A0_0001; dat[1] = 32'hB0B0_0002; dat[2] = 32'hC0C0_0003;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, i == 0, i == 2, (i == 2) ? 2'd2 : 2'd0, dat[i], 1'b0);
      total++;
      if (ram_we !== 1'b1 || ram_waddr !== 4'(i) || ram_wdata !== {nib[i], dat[i]}) begin
        bad++;
        $display("FAIL basic_word%0d we=%b wa=%h wd=%h exp we=1 wa=%0d wd=%h",
                 i, ram_we, ram_waddr, ram_wdata, i, {nib[i], dat[i]});
      end
      total++;
      if (frame_done !== (i == 2)) begin
        bad++; $display("FAIL basic_done%0d got=%b exp=%b", i, frame_done, i == 2);
      end
    end
    total++; if (wr_ptr_commit !== 5'd3) begin bad++; $display("FAIL basic_commit got=%0d exp=3", wr_ptr_commit); end
    idle();
    total++;
    if (frame_done !== 1'b0 || free_words !== 5'd13) begin
      bad++; $display("FAIL basic_after fd=%b free=%0d exp fd=0 free=13", frame_done, free_words);
    end
  endtask

  task automatic test_stray_word();
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h1234_5678, 1'b0);
    total++;
    if (drop_err !== 1'b1 || ram_we !== 1'b0) begin
      bad++; $display("FAIL stray de=%b we=%b exp de=1 we=0", drop_err, ram_we);
    end
    idle();
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL stray_pulse de=%b exp=0", drop_err); end
  endtask

  task automatic test_abort();
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0011, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0022, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0033, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0044, 1'b1);
    total++;
    if (drop_err !== 1'b1 || ram_we !== 1'b0 || wr_ptr_commit !== 5'd1) begin
      bad++; $display("FAIL abort de=%b we=%b cm=%0d exp de=1 we=0 cm=1", drop_err, ram_we, wr_ptr_commit);
    end
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_0055, 1'b0);
    total++;
    if (ram_we !== 1'b1 || ram_waddr !== 4'd1 || frame_done !== 1'b1 || wr_ptr_commit !== 5'd2) begin
      bad++;
      $display("FAIL abort_next we=%b wa=%0d fd=%b cm=%0d exp we=1 wa=1 fd=1 cm=2",
               ram_we, ram_waddr, frame_done, wr_ptr_commit);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, i == 0, 1'b0, 2'd0, 32'(i), 1'b0);
    total++; if (ram_waddr !== 4'd15) begin bad++; $display("FAIL over_last wa=%0d exp=15", ram_waddr); end
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'hDEAD_0000, 1'b0);
    total++;
    if (obs_ready !== 1'b0 || drop_err !== 1'b1 || ram_we !== 1'b0) begin
      bad++; $display("FAIL over_full rdy=%b de=%b we=%b exp rdy=0 de=1 we=0", obs_ready, drop_err, ram_we);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, i == 1, i == 2, 2'd0, 32'hDEAD_0001, 1'b0);
      total++;
      if (obs_ready !== 1'b1 || ram_we !== 1'b0 || drop_err !== 1'b0 || wr_ptr_commit !== 5'd0) begin
        bad++;
        $display("FAIL over_drop%0d rdy=%b we=%b de=%b cm=%0d exp rdy=1 we=0 de=0 cm=0",
                 i, obs_ready, ram_we, drop_err, wr_ptr_commit);
      end
    end
    cycle(1'b1, 1'b1, 1'b1, 2'd3, 32'hBEEF_0000, 1'b0);
    total++;
    if (ram_we !== 1'b1 || ram_waddr !== 4'd0 || frame_done !== 1'b1 || wr_ptr_commit !== 5'd1) begin
      bad++;
      $display("FAIL over_resume we=%b wa=%0d fd=%b cm=%0d exp we=1 wa=0 fd=1 cm=1",
               ram_we, ram_waddr, frame_done, wr_ptr_commit);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_a [4];
    exp_a[0] = 4'hE; exp_a[1] = 4'hF; exp_a[2] = 4'h0; exp_a[3] = 4'h1;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, (i % 10) == 0, (i % 10) == 9, 2'd0, 32'(i), 1'b0);
      if ((i % 10) == 9) rd_ptr_sync = 5'(i + 1);
    end
    total++; if (wr_ptr_commit !== 5'h1E) begin bad++; $display("FAIL wrap_pre cm=%h exp=1e", wr_ptr_commit); end
    idle();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, i == 0, i == 3, 2'd0, 32'h5000 + 32'(i), 1'b0);
      total++;
      if (ram_we !== 1'b1 || ram_waddr !== exp_a[i]) begin
        bad++; $display("FAIL wrap_addr%0d we=%b wa=%h exp we=1 wa=%h", i, ram_we, ram_waddr, exp_a[i]);
      end
    end
    idle();
    total++;
    if (wr_ptr_commit !== 5'h02 || free_words !== 5'd12) begin
      bad++; $display("FAIL wrap_end cm=%h free=%0d exp cm=02 free=12", wr_ptr_commit, free_words);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_0001, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0002, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0003, 1'b0);
    total++;
    if (frame_cnt !== cnt_exp(1)) begin
      bad++; $display("FAIL mid_fcnt got=%0d exp=%0d", frame_cnt, cnt_exp(1));
    end
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0004, 1'b0);
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", obs_ready); end
    total++;
    if ({ram_we, ram_waddr, ram_wdata, wr_ptr_commit, frame_done, drop_err} !== '0
        || free_words !== 5'd16 || frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_regs we=%b wa=%h wd=%h cm=%h fd=%b de=%b free=%0d fc=%0d dc=%0d exp reset",
               ram_we, ram_waddr, ram_wdata, wr_ptr_commit, frame_done, drop_err, free_words,
               frame_cnt, drop_cnt);
    end
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0005, 1'b0);
    total++;
    if (frame_done !== 1'b0 || drop_err !== 1'b1 || ram_we !== 1'b0) begin
      bad++; $display("FAIL mid_tail fd=%b de=%b we=%b exp fd=0 de=1 we=0", frame_done, drop_err, ram_we);
    end
  endtask

  task automatic test_random();
    logic [4:0] avail;
    logic       v, s, e, ab;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      avail = m_base - rd_ptr_sync;
      if ($urandom_range(0, 2) == 0 && avail != 5'd0)
        rd_ptr_sync = rd_ptr_sync + 5'($urandom_range(0, int'(avail)));
      v  = ($urandom_range(0, 3) != 0);
      s  = (m_mode == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 11) == 0);
      e  = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 39) == 0);
      cycle(v, s, e, 2'($urandom_range(0, 3)), $urandom(), ab);
      total++;
      if (obs_ready !== m_ready) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, obs_ready, m_ready);
      end
      total++;
      if (ram_we !== exp_we || (exp_we && (ram_waddr !== exp_waddr || ram_wdata !== exp_wdata))) begin
        bad++;
        $display("FAIL rnd_write cyc=%0d we=%b wa=%h wd=%h exp we=%b wa=%h wd=%h",
                 i, ram_we, ram_waddr, ram_wdata, exp_we, exp_waddr, exp_wdata);
      end
      total++;
      if (wr_ptr_commit !== m_base || frame_done !== exp_fd || drop_err !== exp_de) begin
        bad++;
        $display("FAIL rnd_ctrl cyc=%0d cm=%h fd=%b de=%b exp cm=%h fd=%b de=%b",
                 i, wr_ptr_commit, frame_done, drop_err, m_base, exp_fd, exp_de);
      end
      total++;
      if (free_words !== exp_free) begin
        bad++; $display("FAIL rnd_free cyc=%0d got=%0d exp=%0d", i, free_words, exp_free);
      end
    end
    total++;
    if (frame_cnt !== cnt_exp(m_frames) || drop_cnt !== cnt_exp(m_drops)) begin
      bad++;
      $display("FAIL rnd_counts fc=%0d dc=%0d exp fc=%0d dc=%0d",
               frame_cnt, drop_cnt, cnt_exp(m_frames), cnt_exp(m_drops));
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stray_word();
    test_abort();
    test_oversize();
    test_wrap();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
